vga_window_painter: RTL and testbench

//  Pipelined, parametrised VGA pixel painter. Tiles NUM_WIN image windows
//  (IMG_W x IMG_H each) side by side, starting at (WIN_X0, WIN_Y0).

---
 rtl/vga_window_painter_if.sv | 26 ++
 rtl/vga_window_painter.sv | 237 +++++++++++++++++++++++
 tb/tb_vga_window_painter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_window_painter_if.sv
// Image-memory read bus between the window painter (master) and the frame
// store (slave).
// Handshake: there is no valid/ready pair. The master drives mem_addr and
// mem_sel on every clock. The slave returns mem_pixel for that address
// exactly MEM_LAT clocks later, unconditionally, with no back-pressure.
interface vga_window_painter_if #(
   parameter int AW    = 16,
   parameter int SW    = 1,
   parameter int PIX_W = 3
);
   logic [AW-1:0]    mem_addr;
   logic [SW-1:0]    mem_sel;
   logic [PIX_W-1:0] mem_pixel;

   modport master (
      output mem_addr,
      output mem_sel,
      input  mem_pixel
   );

   modport slave (
      input  mem_addr,
      input  mem_sel,
      output mem_pixel
   );
endinterface

// File: rtl/vga_window_painter.sv
// vga_window_painter
// Tiles NUM_WIN image windows left to right starting at (WIN_X0, WIN_Y0).
// Stage 1 decodes the window and issues the memory read. MEM_LAT delay
// stages carry the hit flag, video_on and the syncs alongside the read. The
// final stage maps the returned palette index to RGB. Total latency from
// x_in/y_in to the outputs is MEM_LAT+2 clocks, and every output is aligned
// to that latency.
module vga_window_painter #(
   parameter int          NUM_WIN  = 2,
   parameter int          IMG_W    = 256,
   parameter int          IMG_H    = 256,
   parameter int          PIX_W    = 3,
   parameter int          WIN_X0   = 125,
   parameter int          WIN_Y0   = 150,
   parameter int          MEM_LAT  = 1,
   parameter logic [23:0] BG_COLOR = 24'h0C1990
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [9:0]            x_in,
   input  logic [9:0]            y_in,
   input  logic                  video_on_in,
   input  logic                  hsync_in,
   input  logic                  vsync_in,
   vga_window_painter_if.master  mem_bus,
   input  logic                  pal_we,
   input  logic [PIX_W-1:0]      pal_addr,
   input  logic [23:0]           pal_data,
   input  logic                  gray_mode,
   output logic [7:0]            red,
   output logic [7:0]            green,
   output logic [7:0]            blue,
   output logic                  hsync_out,
   output logic                  vsync_out,
   output logic                  video_on_out
);

   localparam int CW    = $clog2(IMG_W);
   localparam int RW    = $clog2(IMG_H);
   localparam int AW    = RW + CW;
   localparam int SW    = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
   localparam int DEPTH = 2 ** PIX_W;

   // Power-on palette. Entries past the eight named colours start black.
   function automatic logic [23:0] pal_default(input int idx);
      case (idx)
         0:       return 24'h000000;
         1:       return 24'hFFFF00;
         2:       return 24'h00FF00;
         3:       return 24'hFFFFFF;
         4:       return 24'h000050;
         5:       return 24'h005050;
         6:       return 24'h500050;
         7:       return 24'h505050;
         default: return 24'h000000;
      endcase
   endfunction

   // Repeat the index bits MSB-first until 8 bits are filled, so that the
   // all-ones index maps to full white and zero maps to black.
   function automatic logic [7:0] gray_expand(input logic [PIX_W-1:0] p);
      logic [7:0] g;
      g = 8'h00;
      for (int b = 0; b < 8; b++) begin
         g[7-b] = p[PIX_W-1-(b % PIX_W)];
      end
      return g;
   endfunction

   // ---------------- stage 1: window decode and read issue ----------------
   logic          hit1_q,     hit1_d;
   logic          von1_q,     von1_d;
   logic          hs1_q,      hs1_d;
   logic          vs1_q,      vs1_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [SW-1:0] mem_sel_q,  mem_sel_d;

   logic [31:0]   x_w;
   logic [31:0]   y_w;
   logic          y_hit;

   assign x_w = {22'd0, x_in};
   assign y_w = {22'd0, y_in};

   // Decode which window (if any) covers the current pixel. On a miss the
   // address and select hold, so the memory sees no spurious address
   // changes outside the windows.
   always_comb begin
      hit1_d     = 1'b0;
      mem_addr_d = mem_addr_q;
      mem_sel_d  = mem_sel_q;
      von1_d     = video_on_in;
      hs1_d      = hsync_in;
      vs1_d      = vsync_in;
      y_hit      = (y_w >= 32'(WIN_Y0)) && (y_w < 32'(WIN_Y0 + IMG_H));
      for (int k = 0; k < NUM_WIN; k++) begin
         if (y_hit && (x_w >= 32'(WIN_X0 + k * IMG_W))
                   && (x_w <  32'(WIN_X0 + (k + 1) * IMG_W))) begin
            hit1_d     = 1'b1;
            mem_sel_d  = k[SW-1:0];
            mem_addr_d = {RW'(y_w - 32'(WIN_Y0)),
                          CW'(x_w - 32'(WIN_X0 + k * IMG_W))};
         end
      end
   end

   // Stage 1 registers. The syncs idle high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit1_q     <= 1'b0;
         von1_q     <= 1'b0;
         hs1_q      <= 1'b1;
         vs1_q      <= 1'b1;
         mem_addr_q <= '0;
         mem_sel_q  <= '0;
      end else begin
         hit1_q     <= hit1_d;
         von1_q     <= von1_d;
         hs1_q      <= hs1_d;
         vs1_q      <= vs1_d;
         mem_addr_q <= mem_addr_d;
         mem_sel_q  <= mem_sel_d;
      end
   end

   assign mem_bus.mem_addr = mem_addr_q;
   assign mem_bus.mem_sel  = mem_sel_q;

   // ---------------- delay stages matching the memory latency -------------
   logic [MEM_LAT-1:0] hit_sh_q, hit_sh_d;
   logic [MEM_LAT-1:0] von_sh_q, von_sh_d;
   logic [MEM_LAT-1:0] hs_sh_q,  hs_sh_d;
   logic [MEM_LAT-1:0] vs_sh_q,  vs_sh_d;

   // Shift the control bits one stage per clock while the read is in flight.
   always_comb begin
      hit_sh_d    = hit_sh_q;
      von_sh_d    = von_sh_q;
      hs_sh_d     = hs_sh_q;
      vs_sh_d     = vs_sh_q;
      hit_sh_d[0] = hit1_q;
      von_sh_d[0] = von1_q;
      hs_sh_d[0]  = hs1_q;
      vs_sh_d[0]  = vs1_q;
      for (int i = 1; i < MEM_LAT; i++) begin
         hit_sh_d[i] = hit_sh_q[i-1];
         von_sh_d[i] = von_sh_q[i-1];
         hs_sh_d[i]  = hs_sh_q[i-1];
         vs_sh_d[i]  = vs_sh_q[i-1];
      end
   end

   // Delay-stage registers. Clearing video_on here flushes partial pixels.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_sh_q <= '0;
         von_sh_q <= '0;
         hs_sh_q  <= '1;
         vs_sh_q  <= '1;
      end else begin
         hit_sh_q <= hit_sh_d;
         von_sh_q <= von_sh_d;
         hs_sh_q  <= hs_sh_d;
         vs_sh_q  <= vs_sh_d;
      end
   end

   // ---------------- palette ----------------
   logic [23:0] pal_q [DEPTH];
   logic [23:0] pal_d [DEPTH];

   // A write lands on the clock edge. The final stage reads pal_q, so a
   // same-cycle lookup still sees the old entry.
   always_comb begin
      pal_d = pal_q;
      if (pal_we) begin
         pal_d[pal_addr] = pal_data;
      end
   end

   // Palette storage. Reset reloads the default colours.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            pal_q[i] <= pal_default(i);
         end
      end else begin
         pal_q <= pal_d;
      end
   end

   // ---------------- final stage: colour mapping ----------------
   logic [23:0] rgb_q, rgb_d;
   logic        von_o_q, von_o_d;
   logic        hs_o_q,  hs_o_d;
   logic        vs_o_q,  vs_o_d;

   // Pick blank, background, grayscale or palette colour. gray_mode is read
   // live here so it can change on any clock.
   always_comb begin
      von_o_d = von_sh_q[MEM_LAT-1];
      hs_o_d  = hs_sh_q[MEM_LAT-1];
      vs_o_d  = vs_sh_q[MEM_LAT-1];
      if (!von_sh_q[MEM_LAT-1]) begin
         rgb_d = 24'h000000;
      end else if (!hit_sh_q[MEM_LAT-1]) begin
         rgb_d = BG_COLOR;
      end else if (gray_mode) begin
         rgb_d = {3{gray_expand(mem_bus.mem_pixel)}};
      end else begin
         rgb_d = pal_q[mem_bus.mem_pixel];
      end
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rgb_q   <= 24'h000000;
         von_o_q <= 1'b0;
         hs_o_q  <= 1'b1;
         vs_o_q  <= 1'b1;
      end else begin
         rgb_q   <= rgb_d;
         von_o_q <= von_o_d;
         hs_o_q  <= hs_o_d;
         vs_o_q  <= vs_o_d;
      end
   end

   assign red          = rgb_q[23:16];
   assign green        = rgb_q[15:8];
   assign blue         = rgb_q[7:0];
   assign video_on_out = von_o_q;
   assign hsync_out    = hs_o_q;
   assign vsync_out    = vs_o_q;

endmodule

// File: tb/tb_vga_window_painter.sv
// Bench for vga_window_painter with default parameters (latency 3 clocks).
// It uses a steady-state vector table, followed by hand-written sequences
// for latency, sync delay, palette write timing, gray toggling and
// asynchronous reset.
module tb_vga_window_painter;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- DUT ----------------
   logic [9:0]  x_in, y_in;
   logic        video_on_in, hsync_in, vsync_in;
   logic        pal_we;
   logic [2:0]  pal_addr;
   logic [23:0] pal_data;
   logic        gray_mode;
   logic [7:0]  red, green, blue;
   logic        hsync_out, vsync_out, video_on_out;

   vga_window_painter_if #(.AW(16), .SW(1), .PIX_W(3)) mem_bus ();

   vga_window_painter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .x_in         (x_in),
      .y_in         (y_in),
      .video_on_in  (video_on_in),
      .hsync_in     (hsync_in),
      .vsync_in     (vsync_in),
      .mem_bus      (mem_bus),
      .pal_we       (pal_we),
      .pal_addr     (pal_addr),
      .pal_data     (pal_data),
      .gray_mode    (gray_mode),
      .red          (red),
      .green        (green),
      .blue         (blue),
      .hsync_out    (hsync_out),
      .vsync_out    (vsync_out),
      .video_on_out (video_on_out)
   );

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance one clock and land 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic von,
                        input logic hs, input logic vs, input logic gray,
                        input logic [2:0] pix);
      x_in              = x;
      y_in              = y;
      video_on_in       = von;
      hsync_in          = hs;
      vsync_in          = vs;
      gray_mode         = gray;
      mem_bus.mem_pixel = pix;
   endtask

   // ---------------- vector table ----------------
   typedef struct packed {
      logic [9:0]  x;
      logic [9:0]  y;
      logic        von;
      logic        hs;
      logic        vs;
      logic        gray;
      logic [2:0]  pix;
      logic [15:0] exp_addr;
      logic        exp_sel;
      logic [23:0] exp_rgb;
   } vec_t;

   vec_t vecs[$];

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- main test ----------------
   initial begin
      // Fill the table: x, y, von, hs, vs, gray, pix, addr, sel, rgb.
      vecs.push_back('{10'd126,  10'd151,  1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 16'h0101, 1'b0, 24'hFFFF00});
      vecs.push_back('{10'd381,  10'd160,  1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 16'h0A00, 1'b1, 24'h00FF00});
      vecs.push_back('{10'd380,  10'd160,  1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 16'h0AFF, 1'b0, 24'hFFFFFF});
      vecs.push_back('{10'd637,  10'd160,  1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 16'h0AFF, 1'b0, 24'h0C1990});
      vecs.push_back('{10'd124,  10'd160,  1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 16'h0AFF, 1'b0, 24'h0C1990});
      vecs.push_back('{10'd636,  10'd405,  1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 16'hFFFF, 1'b1, 24'h000050});
      vecs.push_back('{10'd636,  10'd406,  1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 16'hFFFF, 1'b1, 24'h0C1990});
      vecs.push_back('{10'd125,  10'd149,  1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 16'hFFFF, 1'b1, 24'h0C1990});
      vecs.push_back('{10'd125,  10'd150,  1'b1, 1'b1, 1'b1, 1'b0, 3'd6, 16'h0000, 1'b0, 24'h500050});
      vecs.push_back('{10'd200,  10'd200,  1'b0, 1'b1, 1'b1, 1'b0, 3'd7, 16'h324B, 1'b0, 24'h000000});
      vecs.push_back('{10'd200,  10'd200,  1'b1, 1'b1, 1'b1, 1'b1, 3'd5, 16'h324B, 1'b0, 24'hB6B6B6});
      vecs.push_back('{10'd200,  10'd200,  1'b1, 1'b1, 1'b1, 1'b1, 3'd7, 16'h324B, 1'b0, 24'hFFFFFF});
      vecs.push_back('{10'd700,  10'd200,  1'b1, 1'b1, 1'b1, 1'b1, 3'd7, 16'h324B, 1'b0, 24'h0C1990});
      vecs.push_back('{10'd700,  10'd200,  1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 16'h324B, 1'b0, 24'h000000});
      vecs.push_back('{10'd300,  10'd300,  1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 16'h96AF, 1'b0, 24'h005050});
      vecs.push_back('{10'd600,  10'd300,  1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 16'h96DB, 1'b1, 24'h000000});
      vecs.push_back('{10'd1023, 10'd1023, 1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 16'h96DB, 1'b1, 24'h0C1990});
      vecs.push_back('{10'd450,  10'd250,  1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 16'h6445, 1'b1, 24'h6D6D6D});
      vecs.push_back('{10'd450,  10'd250,  1'b1, 1'b1, 1'b1, 1'b0, 3'd7, 16'h6445, 1'b1, 24'h505050});

      // Reset with the first pixel already presented.
      rst_n    = 1'b0;
      pal_we   = 1'b0;
      pal_addr = 3'd0;
      pal_data = 24'h000000;
      drive(10'd126, 10'd151, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1);
      tick();
      tick();
      chk("rst_rgb",  {red, green, blue}, 24'h000000);
      chk("rst_hs",   {23'd0, hsync_out}, 24'd1);
      chk("rst_vs",   {23'd0, vsync_out}, 24'd1);
      chk("rst_von",  {23'd0, video_on_out}, 24'd0);
      chk("rst_addr", {8'd0, mem_bus.mem_addr}, 24'h000000);
      chk("rst_sel",  {23'd0, mem_bus.mem_sel}, 24'd0);

      // Release the reset between edges. The first valid pixel appears
      // exactly 3 clocks later.
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("lat_addr1", {8'd0, mem_bus.mem_addr}, 24'h000101);
      chk("lat_rgb1",  {red, green, blue}, 24'h000000);
      tick();
      chk("lat_rgb2",  {red, green, blue}, 24'h000000);
      chk("lat_von2",  {23'd0, video_on_out}, 24'd0);
      tick();
      chk("lat_rgb3",  {red, green, blue}, 24'hFFFF00);
      chk("lat_von3",  {23'd0, video_on_out}, 24'd1);

      // Table: hold each vector long enough for the pipeline to settle.
      foreach (vecs[i]) begin
         drive(vecs[i].x, vecs[i].y, vecs[i].von, vecs[i].hs, vecs[i].vs,
               vecs[i].gray, vecs[i].pix);
         repeat (4) tick();
         chk($sformatf("v%0d_rgb", i),  {red, green, blue}, vecs[i].exp_rgb);
         chk($sformatf("v%0d_von", i),  {23'd0, video_on_out}, {23'd0, vecs[i].von});
         chk($sformatf("v%0d_hs", i),   {23'd0, hsync_out}, {23'd0, vecs[i].hs});
         chk($sformatf("v%0d_vs", i),   {23'd0, vsync_out}, {23'd0, vecs[i].vs});
         chk($sformatf("v%0d_addr", i), {8'd0, mem_bus.mem_addr}, {8'd0, vecs[i].exp_addr});
         chk($sformatf("v%0d_sel", i),  {23'd0, mem_bus.mem_sel}, {23'd0, vecs[i].exp_sel});
      end

      // Syncs and video_on: a one-clock low pulse emerges exactly 3 clocks later.
      drive(10'd200, 10'd200, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1);
      repeat (4) tick();
      drive(10'd200, 10'd200, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
      tick();
      chk("sync_e1_hs", {23'd0, hsync_out}, 24'd1);
      drive(10'd200, 10'd200, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1);
      tick();
      chk("sync_e2_hs",  {23'd0, hsync_out}, 24'd1);
      chk("sync_e2_rgb", {red, green, blue}, 24'hFFFF00);
      tick();
      chk("sync_e3_hs",  {23'd0, hsync_out}, 24'd0);
      chk("sync_e3_vs",  {23'd0, vsync_out}, 24'd0);
      chk("sync_e3_von", {23'd0, video_on_out}, 24'd0);
      chk("sync_e3_rgb", {red, green, blue}, 24'h000000);
      tick();
      chk("sync_e4_hs",  {23'd0, hsync_out}, 24'd1);
      chk("sync_e4_vs",  {23'd0, vsync_out}, 24'd1);
      chk("sync_e4_rgb", {red, green, blue}, 24'hFFFF00);

      // Palette write while entry 2 is being looked up.
      drive(10'd126, 10'd151, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2);
      repeat (4) tick();
      chk("pal_before", {red, green, blue}, 24'h00FF00);
      pal_we   = 1'b1;
      pal_addr = 3'd2;
      pal_data = 24'h123456;
      tick();
      chk("pal_same_cycle", {red, green, blue}, 24'h00FF00);
      pal_we = 1'b0;
      tick();
      chk("pal_next_cycle", {red, green, blue}, 24'h123456);

      // gray_mode toggled for a single clock acts on that clock only.
      mem_bus.mem_pixel = 3'd5;
      repeat (4) tick();
      chk("gray_pre", {red, green, blue}, 24'h005050);
      gray_mode = 1'b1;
      tick();
      chk("gray_on", {red, green, blue}, 24'hB6B6B6);
      gray_mode = 1'b0;
      tick();
      chk("gray_off", {red, green, blue}, 24'h005050);

      // Asynchronous reset mid-line, asserted between clock edges.
      mem_bus.mem_pixel = 3'd2;
      repeat (3) tick();
      chk("arst_pre", {red, green, blue}, 24'h123456);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_rgb",  {red, green, blue}, 24'h000000);
      chk("arst_von",  {23'd0, video_on_out}, 24'd0);
      chk("arst_hs",   {23'd0, hsync_out}, 24'd1);
      chk("arst_vs",   {23'd0, vsync_out}, 24'd1);
      chk("arst_addr", {8'd0, mem_bus.mem_addr}, 24'h000000);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      chk("arst_flush", {red, green, blue}, 24'h000000);
      tick();
      chk("arst_pal_default", {red, green, blue}, 24'h00FF00);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
      $finish;
   end

endmodule
